// File: rtl/fft_index_sequencer.sv
// ---------------------------------------------------------------------------
// fft_index_sequencer
//
// Generates the complete index stream for one in-place radix-2 DIT FFT pass:
//   mode 0 : bit-reversed load/reorder indices (idx_a = bitrev(k), idx_b = k)
//   mode 1 : per-stage butterfly address pairs plus twiddle ROM index
// The transform length is chosen at start time (2**cfg_log2n, clamped to
// 1..LOG2_N). Elements leave on a ready/valid interface; every output is a
// register, so the element shown is held stable while out_ready is low.
//
// Ports
//   clk        : clock, all logic on rising edge
//   reset      : synchronous active-high reset (priority over clr)
//   clr        : synchronous abort back to IDLE, no done pulse
//   start      : begin a sequence (only honoured in IDLE)
//   mode       : 0 = bit-reverse load, 1 = butterfly (sampled with start)
//   cfg_log2n  : runtime log2 length (sampled with start)
//   out_ready  : consumer accepts the current element
//   out_valid  : current element is valid
//   idx_a      : mode0 bitrev(k); mode1 top butterfly address
//   idx_b      : mode0 k; mode1 bottom butterfly address
//   tw_idx     : twiddle ROM index (0 in mode 0)
//   stage      : current butterfly stage (0 in mode 0)
//   stage_last : final element of the current stage
//   seq_last   : final element of the whole sequence
//   busy       : sequence in progress
//   done       : one-cycle pulse after the final transfer
// ---------------------------------------------------------------------------
module fft_index_sequencer #(
  parameter int LOG2_N = 10,
  parameter int SW     = $clog2(LOG2_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              start,
  input  logic              mode,
  input  logic [4:0]        cfg_log2n,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LOG2_N-1:0] idx_a,
  output logic [LOG2_N-1:0] idx_b,
  output logic [LOG2_N-2:0] tw_idx,
  output logic [SW-1:0]     stage,
  output logic              stage_last,
  output logic              seq_last,
  output logic              busy,
  output logic              done
);

  localparam int         IW    = LOG2_N;
  localparam int         TW    = LOG2_N - 1;
  localparam logic [4:0] L_MAX = 5'(LOG2_N);

  typedef enum logic [1:0] {IDLE, LOAD, BFLY, DONE} state_t;

  state_t        state_reg, state_next;
  logic [IW-1:0] cnt_reg,   cnt_next;    // k in LOAD, j in BFLY
  logic [SW-1:0] stg_reg,   stg_next;
  logic [4:0]    l_reg,     l_next;      // latched, clamped log2 length

  // Stage number widened to the 5-bit length domain so s+1 and L-1-s
  // cannot wrap inside the narrow SW-bit field.
  logic [4:0]    stg5_reg, stg5_next;
  assign stg5_reg  = {{(5-SW){1'b0}}, stg_reg};
  assign stg5_next = {{(5-SW){1'b0}}, stg_next};

  // Registered outputs and their next values
  logic          valid_reg, valid_next;
  logic [IW-1:0] a_reg, a_next, b_reg, b_next;
  logic [TW-1:0] tw_reg, tw_next;
  logic [SW-1:0] st_reg, st_next;
  logic          sl_reg, sl_next, ql_reg, ql_next;
  logic          busy_reg, busy_next, done_reg, done_next;

  logic          xfer;
  logic [IW-1:0] rev_next;
  logic [IW-1:0] mask_next, half_next, pos_next;

  // M-1 for a given L; end of a count is found by compare so the counter
  // never needs a carry bit even at L = LOG2_N.
  function automatic logic [IW-1:0] len_mask(input logic [4:0] l);
    len_mask = {IW{1'b1}} >> (L_MAX - l);
  endfunction

  // Full-width bit reversal of the next counter; shifted down by
  // (LOG2_N - L) it becomes the L-bit reversal with zero upper bits.
  for (genvar gi = 0; gi < IW; gi++) begin : g_rev
    assign rev_next[gi] = cnt_next[IW-1-gi];
  end

  assign xfer = valid_reg & out_ready;

  // Next-state / counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stg_next   = stg_reg;
    l_next     = l_reg;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          l_next     = (cfg_log2n == 5'd0 || cfg_log2n > L_MAX) ? L_MAX : cfg_log2n;
          cnt_next   = '0;
          stg_next   = '0;
          state_next = mode ? BFLY : LOAD;
        end
      end
      LOAD: begin
        if (xfer) begin
          if (cnt_reg == len_mask(l_reg)) state_next = DONE;
          else                            cnt_next   = cnt_reg + IW'(1);
        end
      end
      BFLY: begin
        if (xfer) begin
          if (cnt_reg == (len_mask(l_reg) >> 1)) begin
            cnt_next = '0;
            if (stg5_reg == l_reg - 5'd1) state_next = DONE;
            else                          stg_next   = stg_reg + SW'(1);
          end else begin
            cnt_next = cnt_reg + IW'(1);
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (clr) begin
      state_next = IDLE;
      cnt_next   = '0;
      stg_next   = '0;
    end
  end

  // Element computed from the next counters, so it is registered in the
  // same edge that advances them (element 0 appears right after start).
  always_comb begin
    valid_next = 1'b0;
    a_next     = '0;
    b_next     = '0;
    tw_next    = '0;
    st_next    = '0;
    sl_next    = 1'b0;
    ql_next    = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    mask_next  = len_mask(l_next);
    half_next  = IW'(1) << stg5_next;
    pos_next   = cnt_next & (half_next - IW'(1));
    unique case (state_next)
      LOAD: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
        a_next     = rev_next >> (L_MAX - l_next);
        b_next     = cnt_next;
        sl_next    = (cnt_next == mask_next);
        ql_next    = sl_next;
      end
      BFLY: begin
        valid_next = 1'b1;
        busy_next  = 1'b1;
        // Insert a zero at bit s of j: that bit selects top/bottom of the pair.
        a_next     = ((cnt_next >> stg5_next) << (stg5_next + 5'd1)) | pos_next;
        b_next     = a_next | half_next;
        tw_next    = TW'(pos_next << (l_next - 5'd1 - stg5_next));
        st_next    = stg_next;
        sl_next    = (cnt_next == (mask_next >> 1));
        ql_next    = sl_next && (stg5_next == l_next - 5'd1);
      end
      DONE:    done_next = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      stg_reg   <= '0;
      l_reg     <= L_MAX;
      valid_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      tw_reg    <= '0;
      st_reg    <= '0;
      sl_reg    <= 1'b0;
      ql_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stg_reg   <= stg_next;
      l_reg     <= l_next;
      valid_reg <= valid_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      tw_reg    <= tw_next;
      st_reg    <= st_next;
      sl_reg    <= sl_next;
      ql_reg    <= ql_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign out_valid  = valid_reg;
  assign idx_a      = a_reg;
  assign idx_b      = b_reg;
  assign tw_idx     = tw_reg;
  assign stage      = st_reg;
  assign stage_last = sl_reg;
  assign seq_last   = ql_reg;
  assign busy       = busy_reg;
  assign done       = done_reg;

endmodule

// File: tb/tb_fft_index_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fft_index_sequencer
//
// Directed bench for fft_index_sequencer at LOG2_N = 4. Expected index
// streams are hand-written tables; one line is printed per element seen.
// ---------------------------------------------------------------------------
module tb_fft_index_sequencer;

  localparam int LN  = 4;
  localparam int SWB = $clog2(LN);

  logic           clk = 1'b0;
  logic           reset, clr, start, mode, out_ready;
  logic [4:0]     cfg_log2n;
  logic           out_valid;
  logic [LN-1:0]  idx_a, idx_b;
  logic [LN-2:0]  tw_idx;
  logic [SWB-1:0] stage;
  logic           stage_last, seq_last, busy, done;

  int compared   = 0;
  int mismatched = 0;
  int xfers      = 0;

  int rev4[16]  = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int rev3[8]   = '{0, 4, 2, 6, 1, 5, 3, 7};
  int bf_a[32]  = '{0, 2, 4, 6, 8, 10, 12, 14,
                    0, 1, 4, 5, 8, 9, 12, 13,
                    0, 1, 2, 3, 8, 9, 10, 11,
                    0, 1, 2, 3, 4, 5, 6, 7};
  int bf_b[32]  = '{1, 3, 5, 7, 9, 11, 13, 15,
                    2, 3, 6, 7, 10, 11, 14, 15,
                    4, 5, 6, 7, 12, 13, 14, 15,
                    8, 9, 10, 11, 12, 13, 14, 15};
  int bf_tw[32] = '{0, 0, 0, 0, 0, 0, 0, 0,
                    0, 4, 0, 4, 0, 4, 0, 4,
                    0, 2, 4, 6, 0, 2, 4, 6,
                    0, 1, 2, 3, 4, 5, 6, 7};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) xfers <= xfers + 1;
  end

  fft_index_sequencer #(.LOG2_N(LN)) dut (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .start      (start),
    .mode       (mode),
    .cfg_log2n  (cfg_log2n),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .idx_a      (idx_a),
    .idx_b      (idx_b),
    .tw_idx     (tw_idx),
    .stage      (stage),
    .stage_last (stage_last),
    .seq_last   (seq_last),
    .busy       (busy),
    .done       (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx,
                       input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_elem(input string tag, input int i, input int a, input int b,
                            input int tw, input int st, input bit sl, input bit ql);
    check({tag, ".valid"},      i, 32'(out_valid),  32'd1);
    check({tag, ".busy"},       i, 32'(busy),       32'd1);
    check({tag, ".done"},       i, 32'(done),       32'd0);
    check({tag, ".idx_a"},      i, 32'(idx_a),      32'(a));
    check({tag, ".idx_b"},      i, 32'(idx_b),      32'(b));
    check({tag, ".tw_idx"},     i, 32'(tw_idx),     32'(tw));
    check({tag, ".stage"},      i, 32'(stage),      32'(st));
    check({tag, ".stage_last"}, i, 32'(stage_last), 32'(sl));
    check({tag, ".seq_last"},   i, 32'(seq_last),   32'(ql));
    $display("%s elem=%0d idx_a=%0d idx_b=%0d tw=%0d stage=%0d sl=%0b ql=%0b",
             tag, i, idx_a, idx_b, tw_idx, stage, stage_last, seq_last);
  endtask

  task automatic check_quiet(input string tag, input int i);
    check({tag, ".valid"},      i, 32'(out_valid),  32'd0);
    check({tag, ".busy"},       i, 32'(busy),       32'd0);
    check({tag, ".done"},       i, 32'(done),       32'd0);
    check({tag, ".idx_a"},      i, 32'(idx_a),      32'd0);
    check({tag, ".idx_b"},      i, 32'(idx_b),      32'd0);
    check({tag, ".tw_idx"},     i, 32'(tw_idx),     32'd0);
    check({tag, ".stage"},      i, 32'(stage),      32'd0);
    check({tag, ".stage_last"}, i, 32'(stage_last), 32'd0);
    check({tag, ".seq_last"},   i, 32'(seq_last),   32'd0);
  endtask

  task automatic start_seq(input logic m, input logic [4:0] cfg);
    start     = 1'b1;
    mode      = m;
    cfg_log2n = cfg;
    tick();
    start     = 1'b0;
  endtask

  // After the final transfer: DONE for exactly one cycle, then IDLE.
  task automatic finish_check(input string tag);
    check({tag, ".end_valid"}, 0, 32'(out_valid), 32'd0);
    check({tag, ".end_done"},  0, 32'(done),      32'd1);
    check({tag, ".end_busy"},  0, 32'(busy),      32'd0);
    tick();
    check({tag, ".idle_done"}, 0, 32'(done),      32'd0);
    check({tag, ".idle_valid"},0, 32'(out_valid), 32'd0);
  endtask

  task automatic run_load(input string tag, input logic [4:0] cfg, input int n);
    int ea;
    int x0;
    x0 = xfers;
    start_seq(1'b0, cfg);
    for (int k = 0; k < n; k++) begin
      ea = (n == 8) ? rev3[k] : rev4[k];
      check_elem(tag, k, ea, k, 0, 0, k == n - 1, k == n - 1);
      tick();
    end
    check({tag, ".xfers"}, 0, 32'(xfers - x0), 32'(n));
    finish_check(tag);
  endtask

  task automatic run_bfly(input string tag, input int stall_at);
    int x0;
    x0 = xfers;
    start_seq(1'b1, 5'd4);
    for (int i = 0; i < 32; i++) begin
      check_elem(tag, i, bf_a[i], bf_b[i], bf_tw[i], i / 8, (i % 8) == 7, i == 31);
      if (i == stall_at) begin
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
          tick();
          check_elem({tag, ".hold"}, i, bf_a[i], bf_b[i], bf_tw[i], i / 8,
                     (i % 8) == 7, i == 31);
        end
        out_ready = 1'b1;
      end
      tick();
    end
    check({tag, ".xfers"}, 0, 32'(xfers - x0), 32'd32);
    finish_check(tag);
  endtask

  initial begin
    reset     = 1'b1;
    clr       = 1'b0;
    start     = 1'b0;
    mode      = 1'b0;
    cfg_log2n = 5'd0;
    out_ready = 1'b1;
    tick();
    tick();
    check_quiet("reset", 0);
    reset = 1'b0;
    tick();
    check_quiet("idle", 0);

    // 1: bit-reverse load, L = 4
    run_load("t1", 5'd4, 16);
    // 2: butterfly, L = 4
    run_bfly("t2", -1);
    // 3: bit-reverse load L = 3, then out-of-range lengths clamp to 4
    run_load("t3_cfg3", 5'd3, 8);
    run_load("t3_cfg0", 5'd0, 16);
    run_load("t3_cfg9", 5'd9, 16);
    // 4: back-pressure for 3 cycles at element 5
    run_bfly("t4", 5);

    // 5: start mid-sequence is ignored, clr at element 10 aborts
    start_seq(1'b1, 5'd4);
    for (int i = 0; i < 10; i++) begin
      check_elem("t5", i, bf_a[i], bf_b[i], bf_tw[i], i / 8, (i % 8) == 7, 1'b0);
      if (i == 3) begin
        start     = 1'b1;
        mode      = 1'b0;
        cfg_log2n = 5'd3;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    check_elem("t5", 10, bf_a[10], bf_b[10], bf_tw[10], 1, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_quiet("t5_clr", 0);
    tick();
    check_quiet("t5_clr", 1);
    start_seq(1'b1, 5'd4);
    check_elem("t5_restart", 0, bf_a[0], bf_b[0], bf_tw[0], 0, 1'b0, 1'b0);
    tick();
    check_elem("t5_restart", 1, bf_a[1], bf_b[1], bf_tw[1], 0, 1'b0, 1'b0);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check_quiet("t5_clr2", 0);

    // 6: reset at element 3 of a load sequence, then a clean restart
    start_seq(1'b0, 5'd4);
    for (int k = 0; k < 4; k++) begin
      check_elem("t6", k, rev4[k], k, 0, 0, 1'b0, 1'b0);
      if (k < 3) tick();
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("t6_reset", 0);
    tick();
    check_quiet("t6_reset", 1);
    run_load("t6_restart", 5'd4, 16);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
